// File: rtl/ir_cmd_queue_pkg.sv
// Shared constants for the IR command path: default command width and repeat window.
// Also holds a helper for sizing the repeat-window counter.
package ir_cmd_queue_pkg;

    localparam int IR_CMD_W              = 12;
    localparam int IR_REPEAT_WIN_DEFAULT = 1000;

    // A zero window still needs a 1-bit counter so the logic stays legal.
    function automatic int win_bits(input int win);
        return (win > 0) ? $clog2(win + 1) : 1;
    endfunction

endpackage

// File: rtl/ir_cmd_fifo.sv
// First-word-fall-through FIFO for captured IR commands.
// Full and empty come from the occupancy count; a push into a full FIFO is accepted only alongside a pop.
module ir_cmd_fifo
    import ir_cmd_queue_pkg::*;
#(
    parameter int DATA_W = IR_CMD_W,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [DATA_W-1:0]          din,
    input  logic                       pop,
    output logic [DATA_W-1:0]          dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ir_cmd_queue.sv
// Captures IR commands on the rising edge of in_rdy, drops auto-repeat duplicates,
// and queues accepted commands in a FWFT FIFO with overflow reporting.
module ir_cmd_queue
    import ir_cmd_queue_pkg::*;
#(
    parameter int DATA_W     = IR_CMD_W,
    parameter int DEPTH      = 4,
    parameter int DEDUP      = 1,
    parameter int REPEAT_WIN = IR_REPEAT_WIN_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       in_rdy,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       new_cmd,
    output logic [DATA_W-1:0]          last_cmd,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    input  logic                       clr_overflow
);

    localparam int               WIN_W    = win_bits(REPEAT_WIN);
    localparam logic [WIN_W-1:0] WIN_MAX  = WIN_W'(REPEAT_WIN);
    localparam bit               DEDUP_ON = (DEDUP != 0) && (REPEAT_WIN != 0);

    logic             rdy_q;
    logic [WIN_W-1:0] win_cnt;
    logic             capture;
    logic             dup;
    logic             accept;
    logic             pop;
    logic             full;
    logic             empty;

    assign capture   = in_rdy && !rdy_q;
    assign dup       = DEDUP_ON && (in_data == last_cmd) && (win_cnt < WIN_MAX);
    assign accept    = capture && !dup;
    assign pop       = out_valid && out_ready;
    assign out_valid = !empty;

    ir_cmd_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .din   (in_data),
        .pop   (pop),
        .dout  (out_data),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // rdy_q resets high so an in_rdy held across reset release is not a capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_q    <= 1'b1;
            win_cnt  <= WIN_MAX;
            new_cmd  <= 1'b0;
            last_cmd <= '0;
            overflow <= 1'b0;
        end else begin
            rdy_q   <= in_rdy;
            new_cmd <= accept;
            if (capture) begin
                win_cnt <= '0;
            end else if (win_cnt < WIN_MAX) begin
                win_cnt <= win_cnt + WIN_W'(1);
            end
            if (accept) begin
                last_cmd <= in_data;
            end
            if (clr_overflow) begin
                overflow <= 1'b0;
            end else if (accept && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ir_cmd_queue.sv
// Directed bench for ir_cmd_queue: one instance with repeat filtering, one accepting every capture.
module tb_ir_cmd_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] in_data;
    logic        in_rdy;
    logic [11:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        new_cmd;
    logic [11:0] last_cmd;
    logic [2:0]  count;
    logic        overflow;
    logic        clr_overflow;

    logic [11:0] n_in_data;
    logic        n_in_rdy;
    logic [11:0] n_out_data;
    logic        n_out_valid;
    logic        n_out_ready;
    logic        n_new_cmd;
    logic [11:0] n_last_cmd;
    logic [2:0]  n_count;
    logic        n_overflow;
    logic        n_clr_overflow;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ir_cmd_queue #(.DATA_W(12), .DEPTH(4), .DEDUP(1), .REPEAT_WIN(1000)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_rdy(in_rdy),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .new_cmd(new_cmd), .last_cmd(last_cmd), .count(count),
        .overflow(overflow), .clr_overflow(clr_overflow)
    );

    ir_cmd_queue #(.DATA_W(12), .DEPTH(4), .DEDUP(0), .REPEAT_WIN(1000)) dut_nd (
        .clk(clk), .rst(rst), .in_data(n_in_data), .in_rdy(n_in_rdy),
        .out_data(n_out_data), .out_valid(n_out_valid), .out_ready(n_out_ready),
        .new_cmd(n_new_cmd), .last_cmd(n_last_cmd), .count(n_count),
        .overflow(n_overflow), .clr_overflow(n_clr_overflow)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    // One-cycle in_rdy pulse; the capture edge is the single cyc() inside.
    task automatic pulse(input logic [11:0] d);
        in_data = d;
        in_rdy  = 1'b1;
        cyc();
        in_rdy  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_data = '0; in_rdy = 1'b0; out_ready = 1'b0; clr_overflow = 1'b0;
        n_in_data = '0; n_in_rdy = 1'b0; n_out_ready = 1'b0; n_clr_overflow = 1'b0;
        idle(3);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0h exp=0", out_valid); end
        checks++; if (new_cmd !== 1'b0) begin errors++; $display("FAIL reset_new_cmd got=%0h exp=0", new_cmd); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%0h exp=0", overflow); end
        checks++; if (last_cmd !== 12'h000) begin errors++; $display("FAIL reset_last_cmd got=%0h exp=0", last_cmd); end
        checks++; if (out_data !== 12'h000) begin errors++; $display("FAIL reset_out_data got=%0h exp=0", out_data); end
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_single_capture();
        int pulses = 0;
        in_data = 12'h0A5;
        in_rdy  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (new_cmd === 1'b1) pulses++;
        end
        in_rdy = 1'b0;
        cyc();
        if (new_cmd === 1'b1) pulses++;
        checks++; if (pulses !== 1) begin errors++; $display("FAIL single_pulses got=%0d exp=1", pulses); end
        checks++; if (out_data !== 12'h0A5) begin errors++; $display("FAIL single_out_data got=%0h exp=0a5", out_data); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_out_valid got=%0h exp=1", out_valid); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count got=%0d exp=1", count); end
        checks++; if (last_cmd !== 12'h0A5) begin errors++; $display("FAIL single_last_cmd got=%0h exp=0a5", last_cmd); end
    endtask

    task automatic test_repeat_window();
        idle(99);
        pulse(12'h0A5);
        checks++; if (new_cmd !== 1'b0) begin errors++; $display("FAIL dup100_new_cmd got=%0h exp=0", new_cmd); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL dup100_count got=%0d exp=1", count); end
        for (int i = 0; i < 2; i++) begin
            idle(899);
            pulse(12'h0A5);
            checks++; if (new_cmd !== 1'b0) begin errors++; $display("FAIL dup900_new_cmd got=%0h exp=0", new_cmd); end
        end
        idle(999);
        pulse(12'h0A5);
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL dup1000_count got=%0d exp=1", count); end
        idle(1000);
        pulse(12'h0A5);
        checks++; if (new_cmd !== 1'b1) begin errors++; $display("FAIL gap1001_new_cmd got=%0h exp=1", new_cmd); end
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL gap1001_count got=%0d exp=2", count); end
    endtask

    task automatic test_overflow();
        logic fifth_new = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            checks++; if (out_data !== 12'h0A5) begin errors++; $display("FAIL drain_out_data got=%0h exp=0a5", out_data); end
            cyc();
        end
        out_ready = 1'b0;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL drain_count got=%0d exp=0", count); end
        for (int i = 1; i <= 5; i++) begin
            pulse(12'(i));
            if (i == 5) fifth_new = new_cmd;
            idle(1);
        end
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL ovf_count got=%0d exp=4", count); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%0h exp=1", overflow); end
        checks++; if (last_cmd !== 12'h005) begin errors++; $display("FAIL ovf_last_cmd got=%0h exp=005", last_cmd); end
        checks++; if (fifth_new !== 1'b1) begin errors++; $display("FAIL ovf_new_cmd got=%0h exp=1", fifth_new); end
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            checks++; if (out_data !== 12'(i)) begin errors++; $display("FAIL ovf_pop got=%0h exp=%0h", out_data, i); end
            cyc();
        end
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty got=%0h exp=0", out_valid); end
        clr_overflow = 1'b1;
        cyc();
        clr_overflow = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%0h exp=0", overflow); end
    endtask

    task automatic test_full_push_pop();
        logic [11:0] exp_q [4] = '{12'h012, 12'h013, 12'h014, 12'h015};
        for (int i = 0; i < 4; i++) begin
            pulse(12'h011 + 12'(i));
            idle(1);
        end
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count got=%0d exp=4", count); end
        out_ready = 1'b1;
        pulse(12'h015);
        out_ready = 1'b0;
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL pushpop_count got=%0d exp=4", count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL pushpop_overflow got=%0h exp=0", overflow); end
        checks++; if (new_cmd !== 1'b1) begin errors++; $display("FAIL pushpop_new_cmd got=%0h exp=1", new_cmd); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_data !== exp_q[i]) begin errors++; $display("FAIL pushpop_order got=%0h exp=%0h", out_data, exp_q[i]); end
            cyc();
        end
        out_ready = 1'b0;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL pushpop_drain got=%0d exp=0", count); end
    endtask

    task automatic test_reset_mid_op();
        int stray = 0;
        for (int i = 0; i < 3; i++) begin
            pulse(12'h021 + 12'(i));
            idle(1);
        end
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL midrst_pre_count got=%0d exp=3", count); end
        in_data = 12'h024;
        in_rdy  = 1'b1;
        rst     = 1'b1;
        #1;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL midrst_count got=%0d exp=0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got=%0h exp=0", out_valid); end
        checks++; if (last_cmd !== 12'h000) begin errors++; $display("FAIL midrst_last_cmd got=%0h exp=0", last_cmd); end
        checks++; if (out_data !== 12'h000) begin errors++; $display("FAIL midrst_out_data got=%0h exp=0", out_data); end
        idle(2);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (new_cmd !== 1'b0 || count !== 3'd0) stray++;
        end
        checks++; if (stray !== 0) begin errors++; $display("FAIL midrst_release got=%0d exp=0 stray cycles", stray); end
        in_rdy = 1'b0;
        cyc();
    endtask

    task automatic test_clr_priority();
        for (int i = 0; i < 4; i++) begin
            pulse(12'h031 + 12'(i));
            idle(1);
        end
        clr_overflow = 1'b1;
        pulse(12'h035);
        clr_overflow = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL clrprio_overflow got=%0h exp=0", overflow); end
        checks++; if (last_cmd !== 12'h035) begin errors++; $display("FAIL clrprio_last_cmd got=%0h exp=035", last_cmd); end
        cyc();
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL clrprio_reflag got=%0h exp=0", overflow); end
        out_ready = 1'b1;
        idle(4);
        out_ready = 1'b0;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL clrprio_drain got=%0d exp=0", count); end
    endtask

    task automatic test_no_dedup();
        int pulses = 0;
        for (int k = 0; k < 2; k++) begin
            n_in_data = 12'h0A5;
            n_in_rdy  = 1'b1;
            cyc();
            if (n_new_cmd === 1'b1) pulses++;
            n_in_rdy = 1'b0;
            if (k == 0) idle(9);
        end
        cyc();
        if (n_new_cmd === 1'b1) pulses++;
        checks++; if (pulses !== 2) begin errors++; $display("FAIL nodedup_pulses got=%0d exp=2", pulses); end
        checks++; if (n_count !== 3'd2) begin errors++; $display("FAIL nodedup_count got=%0d exp=2", n_count); end
        checks++; if (n_out_data !== 12'h0A5) begin errors++; $display("FAIL nodedup_out_data got=%0h exp=0a5", n_out_data); end
        n_out_ready = 1'b1;
        idle(2);
        checks++; if (n_count !== 3'd0) begin errors++; $display("FAIL nodedup_drain got=%0d exp=0", n_count); end
        idle(2);
        n_out_ready = 1'b0;
        checks++; if (n_count !== 3'd0) begin errors++; $display("FAIL nodedup_empty_pop got=%0d exp=0", n_count); end
        checks++; if (n_out_valid !== 1'b0) begin errors++; $display("FAIL nodedup_out_valid got=%0h exp=0", n_out_valid); end
    endtask

    initial begin
        test_reset();
        test_single_capture();
        test_repeat_window();
        test_overflow();
        test_full_push_pop();
        test_reset_mid_op();
        test_clr_priority();
        test_no_dedup();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
